// File: rtl/acq_frame_ctrl.sv
// Acquisition frame controller: arms on start/trigger, gates the decimator and
// forwards one frame of samples over AXI-Stream through a single output register.
module acq_frame_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trig_mode,
  input  logic                  trig_in,
  input  logic [REG_WIDTH-1:0]  decimate_cfg,
  input  logic [REG_WIDTH-1:0]  frame_len_cfg,
  output logic [REG_WIDTH-1:0]  dec_decimate,
  output logic                  dec_enable,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  cfg_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [REG_WIDTH-1:0]  dec_q, dec_d, len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  done_q, done_d, ovf_q, ovf_d, cerr_q, cerr_d;
  logic                  trig_prev_q, den_q;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    cerr_d   = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      if (tvalid_q && m_tready) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (frame_len_cfg != '0) begin
              dec_d   = decimate_cfg;
              len_d   = frame_len_cfg;
              cnt_d   = '0;
              ovf_d   = 1'b0;
              state_d = trig_mode ? ARMED : CAPTURE;
            end else begin
              cerr_d = 1'b1;
            end
          end
        end
        ARMED: if (trig_in && !trig_prev_q) state_d = CAPTURE;
        CAPTURE: begin
          if (s_valid) begin
            // Output register frees up this cycle if it is empty or being drained.
            if (!tvalid_q || m_tready) begin
              tdata_d  = s_data;
              tvalid_d = 1'b1;
              cnt_d    = cnt_inc;
              if (cnt_inc == len_q) begin
                tlast_d = 1'b1;
                state_d = DRAIN;
              end
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (tvalid_q && m_tready && tlast_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dec_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cerr_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      den_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      cerr_q      <= cerr_d;
      trig_prev_q <= trig_in;
      den_q       <= (state_d == CAPTURE);
    end
  end

  assign dec_decimate = dec_q;
  assign dec_enable   = den_q;
  assign m_tvalid     = tvalid_q;
  assign m_tdata      = tdata_q;
  assign m_tlast      = tlast_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign cfg_err      = cerr_q;

endmodule

// File: tb/tb_acq_frame_ctrl.sv
// Self-checking bench for acq_frame_ctrl: per-cycle vector table plus directed
// corner sequences; emitted beats are checked against a scoreboard queue.
module tb_acq_frame_ctrl;
  localparam int DW = 12;
  localparam int RW = 32;

  logic          clk, rst_n, start, abort, trig_mode, trig_in;
  logic [RW-1:0] decimate_cfg, frame_len_cfg, dec_decimate;
  logic          dec_enable, s_valid, m_tvalid, m_tlast, m_tready;
  logic [DW-1:0] s_data, m_tdata;
  logic          busy, done, overflow, cfg_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW:0] sb_q[$];

  acq_frame_ctrl #(.DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .trig_mode(trig_mode), .trig_in(trig_in),
    .decimate_cfg(decimate_cfg), .frame_len_cfg(frame_len_cfg),
    .dec_decimate(dec_decimate), .dec_enable(dec_enable),
    .s_valid(s_valid), .s_data(s_data),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .done(done), .overflow(overflow), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat monitor: a handshake is visible at negedge with inputs already stable.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_unexpected: got %0h/%0b expected none", m_tdata, m_tlast);
      end else begin
        logic [DW:0] e;
        e = sb_q.pop_front();
        chk("beat_data_last", {51'd0, m_tlast, m_tdata}, {51'd0, e});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last);
    sb_q.push_back({last, d});
  endtask

  task automatic chk_out(input string tag, input logic b, input logic de,
                         input logic tv, input logic tl, input logic dn, input logic ce);
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".dec_enable"}, 64'(dec_enable), 64'(de));
    chk({tag, ".m_tvalid"}, 64'(m_tvalid), 64'(tv));
    chk({tag, ".m_tlast"}, 64'(m_tlast), 64'(tl));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".cfg_err"}, 64'(cfg_err), 64'(ce));
  endtask

  typedef struct {
    logic          start;
    logic [RW-1:0] flen;
    logic [RW-1:0] dec;
    logic          sv;
    logic [DW-1:0] sd;
    logic          acc;
    logic          last;
    logic          e_busy, e_den, e_tv, e_tl, e_done, e_cerr;
  } vec_t;

  vec_t vt[9];

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; trig_mode = 0; trig_in = 0;
    decimate_cfg = '0; frame_len_cfg = '0; s_valid = 0; s_data = '0; m_tready = 1;
    cyc(); cyc();
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.overflow", 64'(overflow), 64'd0);
    chk("reset.dec_decimate", 64'(dec_decimate), 64'd0);
    rst_n = 1'b1;
    cyc();

    //        start flen dec sv sd      acc last busy den tv tl done cerr
    vt[0] = '{1, 4, 3, 0, 12'h000, 0, 0, 1, 1, 0, 0, 0, 0};
    vt[1] = '{0, 4, 3, 1, 12'h001, 1, 0, 1, 1, 1, 0, 0, 0};
    vt[2] = '{0, 4, 3, 1, 12'h002, 1, 0, 1, 1, 1, 0, 0, 0};
    vt[3] = '{0, 4, 3, 1, 12'h003, 1, 0, 1, 1, 1, 0, 0, 0};
    vt[4] = '{0, 4, 3, 1, 12'h004, 1, 1, 1, 0, 1, 1, 0, 0};
    vt[5] = '{0, 4, 3, 1, 12'h0EE, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[6] = '{0, 4, 3, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[7] = '{1, 0, 7, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 1};
    vt[8] = '{0, 0, 7, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0};
    trig_mode = 0;
    for (int i = 0; i < 9; i++) begin
      start = vt[i].start; frame_len_cfg = vt[i].flen; decimate_cfg = vt[i].dec;
      s_valid = vt[i].sv; s_data = vt[i].sd;
      if (vt[i].acc) push(vt[i].sd, vt[i].last);
      cyc();
      chk_out($sformatf("vec%0d", i), vt[i].e_busy, vt[i].e_den, vt[i].e_tv,
              vt[i].e_tl, vt[i].e_done, vt[i].e_cerr);
    end
    start = 0; s_valid = 0;
    chk("rejected_start.dec_decimate", 64'(dec_decimate), 64'd3);

    // Triggered start: a level already high on arming must not fire.
    trig_mode = 1; trig_in = 1; frame_len_cfg = 2; decimate_cfg = 5; start = 1;
    cyc(); start = 0;
    chk_out("armed", 1, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk_out("armed_hold_high", 1, 0, 0, 0, 0, 0);
    trig_in = 0; cyc();
    chk_out("armed_low", 1, 0, 0, 0, 0, 0);
    trig_in = 1; cyc();
    chk_out("trig_edge", 1, 1, 0, 0, 0, 0);
    chk("trig.dec_decimate", 64'(dec_decimate), 64'd5);
    s_valid = 1; s_data = 12'hA1; push(12'hA1, 0); cyc();
    s_data = 12'hA2; push(12'hA2, 1); cyc();
    chk_out("trig_last", 1, 0, 1, 1, 0, 0);
    s_valid = 0; trig_in = 0; cyc();
    chk_out("trig_done", 0, 0, 0, 0, 1, 0);

    // Backpressure: first sample held, next two dropped; config changes mid-frame ignored.
    trig_mode = 0; frame_len_cfg = 3; start = 1; cyc(); start = 0;
    frame_len_cfg = 1;
    m_tready = 0; s_valid = 1; s_data = 12'h011; push(12'h011, 0); cyc();
    chk("bp.tdata_first", 64'(m_tdata), 64'h011);
    s_data = 12'h022; cyc();
    chk("bp.overflow", 64'(overflow), 64'd1);
    s_data = 12'h033; cyc();
    chk("bp.tdata_held", 64'(m_tdata), 64'h011);
    chk("bp.counter", 64'(dut.cnt_q), 64'd1);
    chk_out("bp_stall", 1, 1, 1, 0, 0, 0);
    s_valid = 0; m_tready = 1; cyc();
    chk_out("bp_release", 1, 1, 0, 0, 0, 0);
    s_valid = 1; s_data = 12'h044; push(12'h044, 0); cyc();
    s_data = 12'h055; push(12'h055, 1); cyc();
    chk_out("bp_last", 1, 0, 1, 1, 0, 0);
    s_valid = 0; cyc();
    chk_out("bp_done", 0, 0, 0, 0, 1, 0);
    chk("bp.overflow_sticky", 64'(overflow), 64'd1);

    // Abort with a beat pending in the output register.
    frame_len_cfg = 3; start = 1; cyc(); start = 0;
    chk("abort.overflow_cleared", 64'(overflow), 64'd0);
    m_tready = 0; s_valid = 1; s_data = 12'h066; cyc();
    chk_out("abort_pre", 1, 1, 1, 0, 0, 0);
    s_valid = 0; abort = 1; cyc(); abort = 0;
    chk_out("abort", 0, 0, 0, 0, 0, 0);
    m_tready = 1; cyc();
    chk_out("abort_after", 0, 0, 0, 0, 0, 0);
    abort = 1; start = 1; cyc(); abort = 0; start = 0;
    chk_out("abort_vs_start", 0, 0, 0, 0, 0, 0);

    // Single-sample frame: first accepted sample is also the last.
    frame_len_cfg = 1; start = 1; cyc(); start = 0;
    s_valid = 1; s_data = 12'h05A; push(12'h05A, 1); m_tready = 0; cyc();
    s_valid = 0;
    chk_out("len1_last", 1, 0, 1, 1, 0, 0);
    m_tready = 1; cyc();
    chk_out("len1_done", 0, 0, 0, 0, 1, 0);

    // Reset in the middle of a frame with overflow set.
    frame_len_cfg = 5; decimate_cfg = 9; start = 1; cyc(); start = 0;
    m_tready = 0; s_valid = 1; s_data = 12'h077; cyc();
    s_data = 12'h078; cyc();
    chk("midrst.overflow_pre", 64'(overflow), 64'd1);
    s_valid = 0; rst_n = 0; cyc();
    chk_out("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst.overflow", 64'(overflow), 64'd0);
    chk("midrst.tdata", 64'(m_tdata), 64'd0);
    chk("midrst.dec_decimate", 64'(dec_decimate), 64'd0);
    rst_n = 1; m_tready = 1; cyc();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
